// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: decodes {pc, inst} from IF, reads the register file combinationally and
// registers the ALU/MEM/WB control bundle toward EX behind a single-entry valid/ready register.
module riscv_decode_stage #(
    parameter int unsigned WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] in_pc,
    input  logic [31:0]            in_inst,
    output logic [4:0]             rs1_addr,
    output logic [4:0]             rs2_addr,
    input  logic [WORD_LENGTH-1:0] rs1_data,
    input  logic [WORD_LENGTH-1:0] rs2_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_exec_fun,
    output logic [WORD_LENGTH-1:0] out_data1,
    output logic [WORD_LENGTH-1:0] out_data2,
    output logic [WORD_LENGTH-1:0] out_store_data,
    output logic [WORD_LENGTH-1:0] out_br_target,
    output logic [WORD_LENGTH-1:0] out_pc,
    output logic [4:0]             out_rd,
    output logic                   out_rf_wen,
    output logic                   out_mem_ren,
    output logic                   out_mem_wen,
    output logic [2:0]             out_mem_funct3,
    output logic [1:0]             out_wb_sel,
    output logic                   out_illegal
);
    // exec_fun encoding shared with riscv_alu; ALU_ADD must stay 0 so reset clears to ADD
    localparam logic [4:0] ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_BEQ  = 5'd10, ALU_BNE  = 5'd11;
    localparam logic [4:0] ALU_BLT  = 5'd12, ALU_BGE  = 5'd13, ALU_BLTU = 5'd14, ALU_BGEU = 5'd15;
    localparam logic [4:0] ALU_JALR = 5'd16;

    typedef struct packed {
        logic [4:0]             exec_fun;
        logic [WORD_LENGTH-1:0] data1;
        logic [WORD_LENGTH-1:0] data2;
        logic [WORD_LENGTH-1:0] store_data;
        logic [WORD_LENGTH-1:0] br_target;
        logic [WORD_LENGTH-1:0] pc;
        logic [4:0]             rd;
        logic                   rf_wen;
        logic                   mem_ren;
        logic                   mem_wen;
        logic [2:0]             mem_funct3;
        logic [1:0]             wb_sel;
        logic                   illegal;
    } bundle_t;

    bundle_t    dec, bundle_d, bundle_q;
    logic       valid_d, valid_q;
    logic       accept;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] alu_fun;
    logic [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign funct7   = in_inst[31:25];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    assign imm_i32 = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u32 = {in_inst[31:12], 12'b0};
    assign imm_j32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Register/immediate ALU function selected by funct3 alone (SUB/SRA handled by the caller)
    always_comb begin
        case (funct3)
            3'b000:  alu_fun = ALU_ADD;
            3'b001:  alu_fun = ALU_SLL;
            3'b010:  alu_fun = ALU_SLT;
            3'b011:  alu_fun = ALU_SLTU;
            3'b100:  alu_fun = ALU_XOR;
            3'b101:  alu_fun = ALU_SRL;
            3'b110:  alu_fun = ALU_OR;
            default: alu_fun = ALU_AND;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.rd      = in_inst[11:7];
        dec.exec_fun = ALU_ADD;
        unique case (opcode)
            7'b0110011: begin
                dec.data1  = rs1_data;
                dec.data2  = rs2_data;
                dec.rf_wen = 1'b1;
                if (funct7 == 7'h00) begin
                    dec.exec_fun = alu_fun;
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    dec.exec_fun = ALU_SUB;
                end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
                    dec.exec_fun = ALU_SRA;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            7'b0010011: begin
                dec.data1    = rs1_data;
                dec.data2    = WORD_LENGTH'($signed(imm_i32));
                dec.rf_wen   = 1'b1;
                dec.exec_fun = alu_fun;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.data2 = WORD_LENGTH'(in_inst[24:20]);
                    if (funct7 != 7'h00 && funct7 != 7'h20) dec.illegal = 1'b1;
                    if (funct3 == 3'b101 && funct7 == 7'h20) dec.exec_fun = ALU_SRA;
                end
            end
            7'b0110111, 7'b0010111: begin
                dec.data1  = (opcode[5]) ? '0 : in_pc;
                dec.data2  = WORD_LENGTH'($signed(imm_u32));
                dec.rf_wen = 1'b1;
            end
            7'b0000011: begin
                dec.data1      = rs1_data;
                dec.data2      = WORD_LENGTH'($signed(imm_i32));
                dec.mem_ren    = 1'b1;
                dec.mem_funct3 = funct3;
                dec.wb_sel     = 2'd1;
                dec.rf_wen     = 1'b1;
            end
            7'b0100011: begin
                dec.data1      = rs1_data;
                dec.data2      = WORD_LENGTH'($signed(imm_s32));
                dec.store_data = rs2_data;
                dec.mem_wen    = 1'b1;
                dec.mem_funct3 = funct3;
            end
            7'b1100011: begin
                dec.data1     = rs1_data;
                dec.data2     = rs2_data;
                dec.br_target = in_pc + WORD_LENGTH'($signed(imm_b32));
                case (funct3)
                    3'b000:  dec.exec_fun = ALU_BEQ;
                    3'b001:  dec.exec_fun = ALU_BNE;
                    3'b100:  dec.exec_fun = ALU_BLT;
                    3'b101:  dec.exec_fun = ALU_BGE;
                    3'b110:  dec.exec_fun = ALU_BLTU;
                    3'b111:  dec.exec_fun = ALU_BGEU;
                    default: dec.illegal  = 1'b1;
                endcase
            end
            7'b1101111: begin
                dec.data1  = in_pc;
                dec.data2  = WORD_LENGTH'($signed(imm_j32));
                dec.wb_sel = 2'd2;
                dec.rf_wen = 1'b1;
            end
            7'b1100111: begin
                dec.data1    = rs1_data;
                dec.data2    = WORD_LENGTH'($signed(imm_i32));
                dec.exec_fun = ALU_JALR;
                dec.wb_sel   = 2'd2;
                dec.rf_wen   = 1'b1;
            end
            7'b0001111: ;
            default: dec.illegal = 1'b1;
        endcase
        // Illegal bundles still travel to EX, but with every side effect stripped
        if (dec.illegal) begin
            dec.exec_fun   = ALU_ADD;
            dec.data1      = '0;
            dec.data2      = '0;
            dec.store_data = '0;
            dec.br_target  = '0;
            dec.rf_wen     = 1'b0;
            dec.mem_ren    = 1'b0;
            dec.mem_wen    = 1'b0;
            dec.mem_funct3 = '0;
            dec.wb_sel     = '0;
        end
        if (dec.rd == 5'd0) dec.rf_wen = 1'b0;
    end

    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_exec_fun   = bundle_q.exec_fun;
    assign out_data1      = bundle_q.data1;
    assign out_data2      = bundle_q.data2;
    assign out_store_data = bundle_q.store_data;
    assign out_br_target  = bundle_q.br_target;
    assign out_pc         = bundle_q.pc;
    assign out_rd         = bundle_q.rd;
    assign out_rf_wen     = bundle_q.rf_wen;
    assign out_mem_ren    = bundle_q.mem_ren;
    assign out_mem_wen    = bundle_q.mem_wen;
    assign out_mem_funct3 = bundle_q.mem_funct3;
    assign out_wb_sel     = bundle_q.wb_sel;
    assign out_illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Scoreboard bench for riscv_decode_stage: directed RV32I cases plus randomized traffic with
// backpressure and flush, checked against a behavioural decoder model.
module tb_riscv_decode_stage;
    localparam logic [4:0] ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4, XOR = 5, SRL = 6, SRA = 7;
    localparam logic [4:0] OR_ = 8, AND_ = 9, BEQ = 10, BNE = 11, BLT = 12, BGE = 13, BLTU = 14;
    localparam logic [4:0] BGEU = 15, JALR = 16;
    localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F,
                                        7'h67, 7'h0F, 7'h73};

    typedef struct packed {
        logic [4:0]  fun;
        logic [31:0] d1, d2, sd, br, pc;
        logic [4:0]  rd;
        logic        rf_wen, mem_ren, mem_wen;
        logic [2:0]  m3;
        logic [1:0]  wb;
        logic        ill;
    } bnd_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
    logic [31:0] in_pc = 0, in_inst = 0, rs1_data = 0, rs2_data = 0;
    logic [4:0] rs1_addr, rs2_addr, out_exec_fun, out_rd;
    logic [31:0] out_data1, out_data2, out_store_data, out_br_target, out_pc;
    logic out_rf_wen, out_mem_ren, out_mem_wen, out_illegal;
    logic [2:0] out_mem_funct3;
    logic [1:0] out_wb_sel;

    int   errors = 0, checks = 0;
    bnd_t exp_q[$];
    bit   mv = 0, exp_in_ready = 1, stall_prev = 0;
    bnd_t held;

    always #5 clk = ~clk;

    riscv_decode_stage #(.WORD_LENGTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_exec_fun(out_exec_fun), .out_data1(out_data1), .out_data2(out_data2),
        .out_store_data(out_store_data), .out_br_target(out_br_target), .out_pc(out_pc),
        .out_rd(out_rd), .out_rf_wen(out_rf_wen), .out_mem_ren(out_mem_ren),
        .out_mem_wen(out_mem_wen), .out_mem_funct3(out_mem_funct3), .out_wb_sel(out_wb_sel),
        .out_illegal(out_illegal)
    );

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bnd_t cur_out();
        return {out_exec_fun, out_data1, out_data2, out_store_data, out_br_target, out_pc, out_rd,
                out_rf_wen, out_mem_ren, out_mem_wen, out_mem_funct3, out_wb_sel, out_illegal};
    endfunction

    function automatic bnd_t mk(logic [4:0] fun, logic [31:0] d1, d2, sd, br, pc, logic [4:0] rd,
                                logic wen, ren, mwen, logic [2:0] m3, logic [1:0] wb, logic ill);
        return {fun, d1, d2, sd, br, pc, rd, wen, ren, mwen, m3, wb, ill};
    endfunction

    // Behavioural decoder: immediates via signed arithmetic, functions via lookup tables
    function automatic bnd_t ref_decode(logic [31:0] inst, pc, r1, r2);
        logic [4:0] opt [8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR_, AND_};
        logic [4:0] brt [8] = '{BEQ, BNE, ADD, ADD, BLT, BGE, BLTU, BGEU};
        int   f3 = int'(inst[14:12]), f7 = int'(inst[31:25]), rd = int'(inst[11:7]);
        int   top = $signed(inst) >>> 31;
        int   ii = $signed(inst) >>> 20;
        int   is = ($signed(inst) >>> 25) * 32 + int'(inst[11:7]);
        int   ib = top * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
        int   ij = top * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048
                   + int'(inst[30:21]) * 2;
        int   iu = int'(inst & 32'hFFFF_F000);
        bit   legal = 1, wr = 0, ren = 0, mw = 0;
        logic [4:0] fun = ADD;
        logic [31:0] d1 = 0, d2 = 0, sd = 0, br = 0;
        logic [2:0] m3 = 0;
        logic [1:0] wb = 0;
        case (inst[6:0])
            7'h33: begin
                d1 = r1; d2 = r2; wr = 1;
                if (f7 == 0) fun = opt[f3];
                else if (f7 == 32 && f3 == 0) fun = SUB;
                else if (f7 == 32 && f3 == 5) fun = SRA;
                else legal = 0;
            end
            7'h13: begin
                d1 = r1; d2 = ii; wr = 1; fun = opt[f3];
                if (f3 == 1 || f3 == 5) begin
                    d2 = int'(inst[24:20]);
                    if (f7 != 0 && f7 != 32) legal = 0;
                    if (f3 == 5 && f7 == 32) fun = SRA;
                end
            end
            7'h37: begin d2 = iu; wr = 1; end
            7'h17: begin d1 = pc; d2 = iu; wr = 1; end
            7'h03: begin d1 = r1; d2 = ii; ren = 1; wb = 1; wr = 1; m3 = inst[14:12]; end
            7'h23: begin d1 = r1; d2 = is; mw = 1; sd = r2; m3 = inst[14:12]; end
            7'h63: begin
                d1 = r1; d2 = r2; br = pc + ib; fun = brt[f3];
                if (f3 == 2 || f3 == 3) legal = 0;
            end
            7'h6F: begin d1 = pc; d2 = ij; wb = 2; wr = 1; end
            7'h67: begin d1 = r1; d2 = ii; fun = JALR; wb = 2; wr = 1; end
            7'h0F: ;
            default: legal = 0;
        endcase
        if (!legal) return mk(ADD, 0, 0, 0, 0, pc, inst[11:7], 0, 0, 0, 0, 0, 1);
        return mk(fun, d1, d2, sd, br, pc, inst[11:7], wr && rd != 0, ren, mw, m3, wb, 0);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] inst = $urandom;
        int k = $urandom_range(0, 11);
        if (k < 11) inst[6:0] = OPS[k];
        if (inst[6:0] == 7'h33 || inst[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0: inst[31:25] = 7'h00;
                1: inst[31:25] = 7'h20;
                default: ;
            endcase
        end
        return inst;
    endfunction

    // One clock cycle of stimulus; entered and left at 1 time unit after a rising edge
    task automatic cycle(input bit v, input logic [31:0] inst, pc, r1, r2, input bit ordy, fl,
                         input bit use_exp, input bnd_t exp);
        bit acc, mv_n;
        in_valid = v; in_inst = inst; in_pc = pc; rs1_data = r1; rs2_data = r2;
        out_ready = ordy; flush = fl;
        exp_in_ready = !mv || ordy;
        acc = v && exp_in_ready && !fl;
        if (fl && mv && !ordy && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        if (acc) exp_q.push_back(use_exp ? exp : ref_decode(inst, pc, r1, r2));
        mv_n = fl ? 1'b0 : acc ? 1'b1 : ordy ? 1'b0 : mv;
        @(posedge clk);
        mv = mv_n;
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            chk("in_ready", 200'(in_ready), 200'(exp_in_ready));
            chk("out_valid", 200'(out_valid), 200'(mv));
            chk("rs_addr", 200'({rs1_addr, rs2_addr}), 200'({in_inst[19:15], in_inst[24:20]}));
            if (stall_prev) chk("stall_stable", 200'(cur_out()), 200'(held));
            stall_prev = out_valid && !out_ready && !flush;
            held = cur_out();
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_bundle", 200'(1), 200'(0));
                else chk("bundle", 200'(cur_out()), 200'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bnd_t none = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 200'({out_valid, cur_out()}), 200'(0));
        #3 rst_n = 1;
        @(posedge clk); #1;

        // addi x1,x2,-5 with rs1=10, then drain
        cycle(1, 32'hFFB10093, 32'h40, 10, 3, 1, 0, 1,
              mk(ADD, 10, 32'hFFFF_FFFB, 0, 0, 32'h40, 1, 1, 0, 0, 0, 0, 0));
        // beq x1,x2,-8 at 0x100
        in_inst = 32'hFE208CE3; #1;
        chk("beq_rs_addr", 200'({rs1_addr, rs2_addr}), 200'({5'd1, 5'd2}));
        cycle(1, 32'hFE208CE3, 32'h100, 32'h11, 32'h22, 1, 0, 1,
              mk(BEQ, 32'h11, 32'h22, 0, 32'hF8, 32'h100, 25, 0, 0, 0, 0, 0, 0));
        cycle(1, 32'h123452B7, 32'h104, 7, 8, 1, 0, 1,
              mk(ADD, 0, 32'h1234_5000, 0, 0, 32'h104, 5, 1, 0, 0, 0, 0, 0));
        cycle(1, 32'h0, 32'h108, 7, 8, 1, 0, 1,
              mk(ADD, 0, 0, 0, 0, 32'h108, 0, 0, 0, 0, 0, 0, 1));
        cycle(0, 0, 0, 0, 0, 1, 0, 0, none);

        // Backpressure: hold one bundle for 3 cycles, then pop and push together
        cycle(1, 32'h00A00513, 32'h200, 1, 2, 0, 0, 0, none);
        repeat (3) cycle(1, 32'h40B50533, 32'h204, 50, 8, 0, 0, 0, none);
        cycle(1, 32'h40B50533, 32'h204, 50, 8, 1, 0, 0, none);
        chk("no_bubble", 200'(out_valid), 200'(1));
        cycle(0, 0, 0, 0, 0, 1, 0, 0, none);

        // Flush while holding a bundle with a new instruction offered
        cycle(1, 32'h00100093, 32'h300, 0, 0, 0, 0, 0, none);
        cycle(1, 32'h00200113, 32'h304, 0, 0, 0, 1, 0, none);
        chk("flush_drop", 200'(out_valid), 200'(0));
        cycle(0, 0, 0, 0, 0, 1, 0, 0, none);

        // Asynchronous reset mid-stream
        cycle(1, 32'h00300193, 32'h400, 0, 0, 0, 0, 0, none);
        #2 rst_n = 0;
        #1 chk("async_reset", 200'({out_valid, in_ready}), 200'({1'b0, 1'b1}));
        exp_q.delete(); mv = 0; in_valid = 0;
        @(posedge clk); #3 rst_n = 1;
        @(posedge clk); #1;
        cycle(1, 32'h00100013, 32'h500, 7, 0, 1, 0, 1,
              mk(ADD, 7, 1, 0, 0, 32'h500, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 7, rand_inst(), $urandom & ~32'h3, $urandom, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 0, none);
        end
        repeat (3) cycle(0, 0, 0, 0, 0, 1, 0, 0, none);
        chk("queue_drained", 200'(exp_q.size()), 200'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
